fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the pipelined MIPS core. Owns the PC register, drives the
//   instruction memory address and captures the fetched word into the IF/ID
//   pipeline register for decode. Takes stall/flush from hazard logic and
//   redirects (branch/jump/jr targets from pc_update) from decode.
//   Freezes on a HALT word until a redirect or reset.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value loaded on reset
//   IMEM_AW     6              instruction memory word-address width
//   HALT_INSTR  32'h0000_000C  encoding that halts fetch (syscall)
// PORTS
//   clk          in   1        clock, all state on posedge
//   reset        in   1        synchronous, active-high
//   stall_f      in   1        hold PC and IF/ID contents
//   flush_d      in   1        load bubble into IF/ID
//   redirect     in   1        load redirect_pc into PC (taken branch/jump/jr)
//   redirect_pc  in   32       redirect target byte address
//   imem_rd      in   32       instruction word at imem_addr (combinational)
//   imem_addr    out  IMEM_AW  pc_f[IMEM_AW+1:2]
//   pc_f         out  32       current fetch PC
//   instr_d      out  32       IF/ID instruction
//   pc_plus4_d   out  32       IF/ID PC+4 of instr_d
//   valid_d      out  1        instr_d is a real instruction (0 = bubble)
//   halted       out  1        fetch FSM in HALT
//   misalign_err out  1        sticky: redirect_pc[1:0] != 0 seen
//   fetch_count  out  32       count of valid instructions loaded into IF/ID
// BEHAVIOUR
//   Reset: pc_f=RESET_PC, instr_d=0, pc_plus4_d=0, valid_d=0, halted=0,
//     misalign_err=0, fetch_count=0, FSM=RUN. Overrides all other inputs.
//   Bubble = {instr_d=0 (sll $0 nop), pc_plus4_d=0, valid_d=0}.
//   FSM RUN, per cycle, priority top-down:
//     redirect: pc_f<={redirect_pc[31:2],2'b00}; IF/ID<=bubble; ignores stall_f.
//       If redirect_pc[1:0]!=0 set misalign_err (cleared only by reset).
//     flush_d (no redirect): IF/ID<=bubble; PC advances unless stall_f.
//     stall_f: pc_f and IF/ID hold; fetch_count holds.
//     else: IF/ID<={imem_rd, pc_f+4, 1}; pc_f<=pc_f+4; fetch_count+=1.
//       If imem_rd==HALT_INSTR: word still enters IF/ID valid; pc_f<=pc_f+4;
//       FSM->HALT.
//   FSM HALT: halted=1; pc_f frozen; IF/ID<=bubble each cycle unless
//     stall_f (hold). redirect -> RUN with pc_f<=target, IF/ID<=bubble
//     (halt was on a squashed path). flush_d alone does not leave HALT.
//   Latency: word at pc_f appears on instr_d the next edge (1 cycle).
//   First valid_d=1 is the 1st edge after reset deasserts.
//   Arithmetic: pc_f+4 wraps modulo 2^32; fetch_count wraps 2^32-1 -> 0.
//   imem_addr truncates PC; addresses beyond 4*2^IMEM_AW alias, no error.
//   fetch_count increments only when a valid word is loaded (not bubble/hold).
// TESTING
//   1 memfile words W0..W3 at 0x0..0xC, reset 2 cycles then run -> instr_d
//     W0,W1,W2,W3 on successive edges, pc_plus4_d 4,8,12,16, fetch_count 4.
//   2 stall_f=1 for 2 cycles while pc_f=0x8 -> pc_f stays 0x8, instr_d=W1,
//     fetch_count unchanged; release -> instr_d=W2 next edge.
//   3 redirect=1, redirect_pc=0x40 at pc_f=0x10 (stall_f=1 too) -> pc_f=0x40,
//     valid_d=0 one cycle, then instr_d=word@0x40, pc_plus4_d=0x44.
//   4 HALT_INSTR at 0x0C -> instr_d=0x0000000C valid, then halted=1, pc_f=0x10
//     frozen, valid_d=0 for 10 cycles; redirect to 0x20 -> halted=0, resumes.
//   5 redirect_pc=0x22 -> pc_f=0x20, misalign_err=1, stays 1 until reset.
//   6 reset asserted mid-run with stall_f, flush_d, redirect all high ->
//     all outputs at reset values next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Bundle between the IF stage and its surroundings: hazard/decode controls,
// instruction memory port, the IF/ID register contents and fetch status.
interface fetch_stage_if #(
  parameter int IMEM_AW = 6
);
  logic               stall_f;
  logic               flush_d;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        imem_rd;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc_f;
  logic [31:0]        instr_d;
  logic [31:0]        pc_plus4_d;
  logic               valid_d;
  logic               halted;
  logic               misalign_err;
  logic [31:0]        fetch_count;
  logic               fsm_state;    // debug view of the fetch FSM: 0 = RUN, 1 = HALT

  modport slave (
    input  stall_f, flush_d, redirect, redirect_pc, imem_rd,
    output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, halted,
           misalign_err, fetch_count, fsm_state
  );

  modport master (
    output stall_f, flush_d, redirect, redirect_pc, imem_rd,
    input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, halted,
           misalign_err, fetch_count, fsm_state
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction memory addressing and the IF/ID
// pipeline register, with a RUN/HALT fetch FSM that freezes on a syscall word.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_AW    = 6,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_next_seq;
  logic [31:0] redirect_target;
  logic        redirect_misaligned;

  assign pc_next_seq         = bus.pc_f + 32'd4;
  assign redirect_target     = {bus.redirect_pc[31:2], 2'b00};
  assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign bus.imem_addr       = bus.pc_f[IMEM_AW+1:2];
  assign bus.fsm_state       = state;

  // Control priority each cycle: redirect beats flush_d beats stall_f beats a
  // normal fetch. A redirect always wins, even over a stall, since the
  // instruction being held belongs to a squashed path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      bus.pc_f         <= RESET_PC;
      bus.instr_d      <= 32'd0;
      bus.pc_plus4_d   <= 32'd0;
      bus.valid_d      <= 1'b0;
      bus.halted       <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.fetch_count  <= 32'd0;
    end else if (bus.redirect) begin
      state          <= RUN;
      bus.halted     <= 1'b0;
      bus.pc_f       <= redirect_target;
      bus.instr_d    <= 32'd0;
      bus.pc_plus4_d <= 32'd0;
      bus.valid_d    <= 1'b0;
      if (redirect_misaligned) begin
        bus.misalign_err <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (bus.flush_d) begin
            bus.instr_d    <= 32'd0;
            bus.pc_plus4_d <= 32'd0;
            bus.valid_d    <= 1'b0;
            if (!bus.stall_f) begin
              bus.pc_f <= pc_next_seq;
            end
          end else if (!bus.stall_f) begin
            bus.instr_d     <= bus.imem_rd;
            bus.pc_plus4_d  <= pc_next_seq;
            bus.valid_d     <= 1'b1;
            bus.pc_f        <= pc_next_seq;
            bus.fetch_count <= bus.fetch_count + 32'd1;
            if (bus.imem_rd == HALT_INSTR) begin
              state      <= HALT;
              bus.halted <= 1'b1;
            end
          end
        end
        HALT: begin
          // PC stays frozen; decode sees bubbles unless it is holding IF/ID.
          if (!bus.stall_f) begin
            bus.instr_d    <= 32'd0;
            bus.pc_plus4_d <= 32'd0;
            bus.valid_d    <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the steady-state
// behaviour plus hand-written halt and mid-run reset sequences.
module tb_fetch_stage;

  localparam logic [31:0] HALT_W = 32'h0000_000C;

  logic clk;
  logic reset;
  logic [31:0] mem [64];
  int n_vec;
  int n_bad;

  fetch_stage_if #(.IMEM_AW(6)) bus ();

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_AW    (6),
    .HALT_INSTR (HALT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.imem_rd = mem[bus.imem_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic        e_halt;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [17];

  // memory word stored at byte address a (aliased to 64 words)
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hA000_0000 | ((a >> 2) & 32'h3F);
  endfunction

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    bus.stall_f     = s;
    bus.flush_d     = f;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pp4, input logic v, input logic h, input logic m,
                       input logic [31:0] cnt);
    n_vec++;
    if (bus.pc_f !== pc || bus.instr_d !== instr || bus.pc_plus4_d !== pp4 ||
        bus.valid_d !== v || bus.halted !== h || bus.misalign_err !== m ||
        bus.fetch_count !== cnt) begin
      n_bad++;
      $display("FAIL %s: got pc=%h instr=%h pp4=%h v=%b h=%b m=%b cnt=%0d / exp pc=%h instr=%h pp4=%h v=%b h=%b m=%b cnt=%0d",
               name, bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.halted,
               bus.misalign_err, bus.fetch_count, pc, instr, pp4, v, h, m, cnt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);

    //            st fl rd rpc            pc             instr          pp4            v  h  m  cnt
    vecs[0]  = '{0, 0, 0, 32'h0,         32'h4,         w(32'h0),      32'h4,         1, 0, 0, 32'd1};
    vecs[1]  = '{0, 0, 0, 32'h0,         32'h8,         w(32'h4),      32'h8,         1, 0, 0, 32'd2};
    vecs[2]  = '{1, 0, 0, 32'h0,         32'h8,         w(32'h4),      32'h8,         1, 0, 0, 32'd2};
    vecs[3]  = '{1, 0, 0, 32'h0,         32'h8,         w(32'h4),      32'h8,         1, 0, 0, 32'd2};
    vecs[4]  = '{0, 0, 0, 32'h0,         32'hC,         w(32'h8),      32'hC,         1, 0, 0, 32'd3};
    vecs[5]  = '{0, 0, 0, 32'h0,         32'h10,        w(32'hC),      32'h10,        1, 0, 0, 32'd4};
    vecs[6]  = '{1, 0, 1, 32'h40,        32'h40,        32'h0,         32'h0,         0, 0, 0, 32'd4};
    vecs[7]  = '{0, 0, 0, 32'h0,         32'h44,        w(32'h40),     32'h44,        1, 0, 0, 32'd5};
    vecs[8]  = '{0, 1, 0, 32'h0,         32'h48,        32'h0,         32'h0,         0, 0, 0, 32'd5};
    vecs[9]  = '{1, 1, 0, 32'h0,         32'h48,        32'h0,         32'h0,         0, 0, 0, 32'd5};
    vecs[10] = '{0, 0, 0, 32'h0,         32'h4C,        w(32'h48),     32'h4C,        1, 0, 0, 32'd6};
    vecs[11] = '{0, 0, 1, 32'h22,        32'h20,        32'h0,         32'h0,         0, 0, 1, 32'd6};
    vecs[12] = '{0, 0, 0, 32'h0,         32'h24,        w(32'h20),     32'h24,        1, 0, 1, 32'd7};
    vecs[13] = '{0, 1, 1, 32'h100,       32'h100,       32'h0,         32'h0,         0, 0, 1, 32'd7};
    vecs[14] = '{0, 0, 0, 32'h0,         32'h104,       w(32'h100),    32'h104,       1, 0, 1, 32'd8};
    vecs[15] = '{0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 0, 1, 32'd8};
    vecs[16] = '{0, 0, 0, 32'h0,         32'h0,         w(32'hFFFF_FFFC), 32'h0,      1, 0, 1, 32'd9};

    reset = 1'b1;
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    check("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc);
      check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
            vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // halt on syscall word at 0xC, then resume via redirect
    reset = 1'b1;
    drive(0, 0, 0, 32'h0);
    check("halt_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'd0);
    reset = 1'b0;
    mem[3] = HALT_W;
    drive(0, 0, 0, 32'h0);
    check("halt_w0", 32'h4, w(32'h0), 32'h4, 1, 0, 0, 32'd1);
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    check("halt_w2", 32'hC, w(32'h8), 32'hC, 1, 0, 0, 32'd3);
    drive(0, 0, 0, 32'h0);
    check("halt_enter", 32'h10, HALT_W, 32'h10, 1, 1, 0, 32'd4);
    drive(1, 0, 0, 32'h0);
    check("halt_stall", 32'h10, HALT_W, 32'h10, 1, 1, 0, 32'd4);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 32'h0);
      check($sformatf("halt_idle%0d", i), 32'h10, 32'h0, 32'h0, 0, 1, 0, 32'd4);
    end
    drive(0, 1, 0, 32'h0);
    check("halt_flush", 32'h10, 32'h0, 32'h0, 0, 1, 0, 32'd4);
    drive(0, 0, 1, 32'h20);
    check("halt_redirect", 32'h20, 32'h0, 32'h0, 0, 0, 0, 32'd4);
    drive(0, 0, 0, 32'h0);
    check("halt_resume", 32'h24, w(32'h20), 32'h24, 1, 0, 0, 32'd5);
    mem[3] = 32'hA000_0003;

    // reset mid-run with every control input asserted
    reset = 1'b1;
    drive(1, 1, 1, 32'h22);
    check("midrun_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 32'h0);
    check("midrun_restart", 32'h4, w(32'h0), 32'h4, 1, 0, 0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
